// File: rtl/riu_fetch_stage.sv
// riu_fetch_stage: RV32 instruction fetch stage ahead of the RIU control unit.
// Holds the PC and fetches words from imem over a req/ack handshake.
// It latches each word into the IR and exposes the decoded RV32 fields.
// Ports:
//   clk, rst (async, active-high)
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction memory handshake
//   stall                                  : downstream back-pressure
//   instr_valid, pc_out                    : IR status and its PC
//   opcode, rd, funct3, rs1, rs2, funct7, imm12, imm20 : slices of the IR
// Option: `define RIU_REDIRECT_EN adds redirect_valid/redirect_pc, which reload the PC.
module riu_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 12
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   input  logic               stall,
   output logic               instr_valid,
   output logic [31:0]        pc_out,
   output logic [6:0]         opcode,
   output logic [4:0]         rd,
   output logic [2:0]         funct3,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic [6:0]         funct7,
   output logic [11:0]        imm12,
   output logic [19:0]        imm20
`ifdef RIU_REDIRECT_EN
   ,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc
`endif
);

   typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic [31:0] pc_out_q;
   logic        valid_q;
   logic        discard_q;

   logic busy;
   logic take;
   logic redir;
   logic capture;

   assign busy = (state_q == REQ) || (state_q == WAIT);
   assign take = busy && imem_ack;

`ifdef RIU_REDIRECT_EN
   assign redir = redirect_valid && (state_q != BOOT);
`else
   assign redir = 1'b0;
`endif

   // A response that belongs to a redirected-away request never loads the IR.
   assign capture = take && !discard_q && !redir;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT: state_d = REQ;
         REQ, WAIT: begin
            if (take && !discard_q)
               // Back-pressure only counts once the IR holds something.
               state_d = (stall && valid_q) ? HOLD : REQ;
            else
               state_d = WAIT;
         end
         HOLD: state_d = stall ? HOLD : REQ;
         default: state_d = BOOT;
      endcase
      if (redir)
         state_d = REQ;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= BOOT;
         pc_q      <= {RESET_PC[31:2], 2'b00};
         ir_q      <= NOP;
         pc_out_q  <= 32'h0;
         valid_q   <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         state_q <= state_d;
`ifdef RIU_REDIRECT_EN
         if (redir) begin
            pc_q    <= {redirect_pc[31:2], 2'b00};
            valid_q <= 1'b0;
         end else
`endif
         if (capture) begin
            ir_q     <= imem_rdata;
            pc_out_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            valid_q  <= 1'b1;
         end
         // Remember a request left in flight by a redirect, so its ack is dropped.
         if (redir)
            discard_q <= busy && !imem_ack;
         else if (take)
            discard_q <= 1'b0;
      end
   end

   assign imem_req    = busy;
   assign imem_addr   = pc_q[IMEM_AW+1:2];
   assign instr_valid = valid_q;
   assign pc_out      = pc_out_q;
   assign opcode      = ir_q[6:0];
   assign rd          = ir_q[11:7];
   assign funct3      = ir_q[14:12];
   assign rs1         = ir_q[19:15];
   assign rs2         = ir_q[24:20];
   assign funct7      = ir_q[31:25];
   assign imm12       = ir_q[31:20];
   assign imm20       = ir_q[31:12];

endmodule

// File: tb/tb_riu_fetch_stage.sv
// tb_riu_fetch_stage: self-checking bench for riu_fetch_stage.
// A memory model drives the DUT, and a scoreboard checks every captured instruction.
module tb_riu_fetch_stage;

   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack = 1'b0;
   logic [31:0]   imem_rdata = 32'h0;
   logic          stall = 1'b0;
   logic          instr_valid;
   logic [31:0]   pc_out;
   logic [6:0]    opcode, funct7;
   logic [4:0]    rd, rs1, rs2;
   logic [2:0]    funct3;
   logic [11:0]   imm12;
   logic [19:0]   imm20;
`ifdef RIU_REDIRECT_EN
   logic          redirect_valid = 1'b0;
   logic [31:0]   redirect_pc = 32'h0;
`endif

   logic          w_req, w_valid;
   logic [AW-1:0] w_addr;
   logic [31:0]   w_pc;
   logic [6:0]    w_op, w_f7;
   logic [4:0]    w_rd, w_rs1, w_rs2;
   logic [2:0]    w_f3;
   logic [11:0]   w_i12;
   logic [19:0]   w_i20;
   logic          w_ack;
   logic [31:0]   w_rdata;

   always #5 clk = ~clk;

   riu_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .instr_valid(instr_valid), .pc_out(pc_out),
      .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
      .rs2(rs2), .funct7(funct7), .imm12(imm12), .imm20(imm20)
`ifdef RIU_REDIRECT_EN
      , .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`endif
   );

   assign w_ack   = w_req;
   assign w_rdata = {w_addr, 20'h00093};

   riu_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(AW)) u_wrap (
      .clk(clk), .rst(rst),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_ack), .imem_rdata(w_rdata),
      .stall(1'b0), .instr_valid(w_valid), .pc_out(w_pc),
      .opcode(w_op), .rd(w_rd), .funct3(w_f3), .rs1(w_rs1),
      .rs2(w_rs2), .funct7(w_f7), .imm12(w_i12), .imm20(w_i20)
`ifdef RIU_REDIRECT_EN
      , .redirect_valid(1'b0), .redirect_pc(32'h0)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  f7;
      logic [11:0] imm12;
      logic [19:0] imm20;
   } exp_t;

   typedef struct {
      logic [31:0] word;
      exp_t        e;
   } vec_t;

   vec_t vt [5];
   exp_t sb [$];

   int checks = 0;
   int failures = 0;
   int pops = 0;
   int exp_idx = 0;
   int cnt = 0;
   int dly = 1;
   bit rnd_dly = 0;
   bit use_table = 0;
   bit force_ack = 0;
   bit mem_hold = 0;
   bit bench_discard = 0;
   bit prev_cap = 0;
   bit prev_req = 0;
   bit prev_ack = 0;
   logic [AW-1:0] prev_addr = '0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_of(logic [AW-1:0] a);
      if (use_table && a < 5)
         return vt[a].word;
      return 32'h0010_0093 + ({20'h0, a} << 20);
   endfunction

   function automatic exp_t exp_of(int idx);
      exp_t e;
      logic [11:0] m;
      if (use_table && idx < 5) begin
         e = vt[idx].e;
      end else begin
         m = 12'(idx + 1);
         e.opcode = 7'h13;
         e.rd = 5'd1;
         e.f3 = 3'd0;
         e.rs1 = 5'd0;
         e.rs2 = m[4:0];
         e.f7 = m[11:5];
         e.imm12 = m;
         e.imm20 = {m, 8'h00};
      end
      e.pc = 32'(idx) << 2;
      return e;
   endfunction

   task automatic step();
      exp_t e;
      @(negedge clk);
      if (prev_cap) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual=empty required=entry");
         end else begin
            e = sb.pop_front();
            pops++;
            chk("valid", 32'(instr_valid), 32'd1);
            chk("pc_out", pc_out, e.pc);
            chk("opcode", 32'(opcode), 32'(e.opcode));
            chk("rd", 32'(rd), 32'(e.rd));
            chk("funct3", 32'(funct3), 32'(e.f3));
            chk("rs1", 32'(rs1), 32'(e.rs1));
            chk("rs2", 32'(rs2), 32'(e.rs2));
            chk("funct7", 32'(funct7), 32'(e.f7));
            chk("imm12", 32'(imm12), 32'(e.imm12));
            chk("imm20", 32'(imm20), 32'(e.imm20));
         end
      end
      if (prev_req && !prev_ack) begin
         chk("req_held", 32'(imem_req), 32'd1);
         chk("addr_stable", 32'(imem_addr), 32'(prev_addr));
      end
      imem_ack = 1'b0;
      imem_rdata = 32'hBAD0_0BAD;
      if (imem_req && !mem_hold) begin
         if (cnt >= dly) begin
            imem_ack = 1'b1;
            imem_rdata = word_of(imem_addr);
         end else begin
            cnt++;
         end
      end else if (!imem_req && force_ack) begin
         imem_ack = 1'b1;
         imem_rdata = 32'hFFFF_FFFF;
      end
      prev_cap = 0;
      if (imem_req && imem_ack) begin
         cnt = 0;
         if (rnd_dly)
            dly = $urandom_range(0, 4);
         if (bench_discard) begin
            bench_discard = 0;
         end else begin
            chk("fetch_addr", 32'(imem_addr), 32'(exp_idx) & 32'hFFF);
            sb.push_back(exp_of(exp_idx));
            exp_idx++;
            prev_cap = 1;
         end
      end
      prev_req = imem_req;
      prev_ack = imem_ack;
      prev_addr = imem_addr;
   endtask

   task automatic clear_bench();
      sb.delete();
      prev_cap = 0;
      prev_req = 0;
      prev_ack = 0;
      cnt = 0;
      exp_idx = 0;
      pops = 0;
      bench_discard = 0;
      force_ack = 0;
      mem_hold = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      stall = 1'b0;
      imem_ack = 1'b0;
      clear_bench();
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_opcode", 32'(opcode), 32'h13);
      chk("rst_imm20", 32'(imm20), 32'd0);
      rst = 1'b0;
   endtask

   task automatic run_pops(int n, int budget, string tag);
      int k;
      k = 0;
      while (pops < n && k < budget) begin
         step();
         k++;
      end
      if (pops < n) begin
         checks++;
         failures++;
         $display("FAIL timeout_%s actual=%0d required=%0d", tag, pops, n);
      end
   endtask

   initial begin
      int k;
      vt[0].word = 32'h4020_8133;
      vt[0].e = '{pc: 0, opcode: 7'h33, rd: 2, f3: 0, rs1: 1, rs2: 2,
                  f7: 7'h20, imm12: 12'h402, imm20: 20'h40208};
      vt[1].word = 32'h0010_0093;
      vt[1].e = '{pc: 0, opcode: 7'h13, rd: 1, f3: 0, rs1: 0, rs2: 1,
                  f7: 7'h00, imm12: 12'h001, imm20: 20'h00100};
      vt[2].word = 32'hFFF0_0113;
      vt[2].e = '{pc: 0, opcode: 7'h13, rd: 2, f3: 0, rs1: 0, rs2: 5'h1F,
                  f7: 7'h7F, imm12: 12'hFFF, imm20: 20'hFFF00};
      vt[3].word = 32'h0000_A183;
      vt[3].e = '{pc: 0, opcode: 7'h03, rd: 3, f3: 2, rs1: 1, rs2: 0,
                  f7: 7'h00, imm12: 12'h000, imm20: 20'h0000A};
      vt[4].word = 32'h1234_50B7;
      vt[4].e = '{pc: 0, opcode: 7'h37, rd: 1, f3: 5, rs1: 8, rs2: 3,
                  f7: 7'h09, imm12: 12'h123, imm20: 20'h12345};

      // Basic fetch and first-ack latency; wrap instance checked alongside.
      dly = 1;
      do_reset();
      chk("wrap_rst_valid", 32'(w_valid), 32'd0);
      chk("wrap_rst_req", 32'(w_req), 32'd0);
      step();
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", 32'(imem_addr), 32'd0);
      chk("wrap_req", 32'(w_req), 32'd1);
      chk("wrap_addr0", 32'(w_addr), 32'hFFE);
      step();
      chk("valid_at_ack", 32'(instr_valid), 32'd0);
      chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
      chk("wrap_addr1", 32'(w_addr), 32'hFFF);
      step();
      chk("valid_after_ack", 32'(instr_valid), 32'd1);
      chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
      chk("wrap_addr2", 32'(w_addr), 32'h000);
      step();
      chk("wrap_pc2", w_pc, 32'h0000_0000);
      chk("wrap_noX", 32'($isunknown({w_req, w_addr, w_valid, w_pc, w_op,
         w_rd, w_f3, w_rs1, w_rs2, w_f7, w_i12, w_i20})), 32'd0);
      step();
      chk("wrap_pc3", w_pc, 32'h0000_0004);
      run_pops(3, 20, "basic");

      // Field decode from a table of instruction words.
      use_table = 1;
      do_reset();
      for (int i = 0; i < 5; i++)
         run_pops(i + 1, 10, "table");
      use_table = 0;

      // Stall after the 2nd instruction, with a spurious ack during HOLD.
      do_reset();
      k = 0;
      do begin
         step();
         k++;
      end while (!(imem_req && imem_ack && imem_addr == 12'd1) && k < 20);
      chk("stall_setup", 32'(imem_addr), 32'd1);
      stall = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk("hold_req", 32'(imem_req), 32'd0);
         chk("hold_pc", pc_out, 32'd4);
         chk("hold_imm12", 32'(imm12), 32'd2);
         chk("hold_valid", 32'(instr_valid), 32'd1);
         force_ack = (c == 2);
      end
      stall = 1'b0;
      step();
      chk("resume_req", 32'(imem_req), 32'd1);
      chk("resume_addr", 32'(imem_addr), 32'd2);
      chk("resume_pc", pc_out, 32'd4);

      // Stall before any valid instruction is ignored, then random ack delays.
      stall = 1'b1;
      do_reset();
      run_pops(1, 10, "stall_inv");
      chk("stall_ignored", 32'(imem_req), 32'd1);
      stall = 1'b0;
      rnd_dly = 1;
      k = 0;
      while (exp_idx < 66 && k < 1000) begin
         step();
         stall = ($urandom_range(0, 7) == 0);
         k++;
      end
      chk("rand_count", 32'(exp_idx >= 66), 32'd1);
      stall = 1'b0;
      rnd_dly = 0;
      mem_hold = 1;
      step();
      step();
      chk("rand_drain", 32'(sb.size()), 32'd0);
      chk("rand_pops", 32'(pops), 32'(exp_idx));

      // Reset in the middle of WAIT, then a late ack during BOOT.
      dly = 4;
      do_reset();
      run_pops(1, 20, "mid_wait");
      k = 0;
      do begin
         step();
         k++;
      end while (!(imem_req && cnt >= 2) && k < 20);
      chk("mid_wait_req", 32'(imem_req), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      chk("mid_rst_req", 32'(imem_req), 32'd0);
      clear_bench();
      @(negedge clk);
      rst = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      dly = 1;
      step();
      chk("boot_ack_valid", 32'(instr_valid), 32'd0);
      chk("boot_ack_addr", 32'(imem_addr), 32'd0);
      chk("boot_ack_req", 32'(imem_req), 32'd1);
      run_pops(1, 10, "after_rst");

`ifdef RIU_REDIRECT_EN
      // Redirect while a request is outstanding in WAIT.
      dly = 2;
      do_reset();
      run_pops(2, 20, "redir_pre");
      k = 0;
      do begin
         step();
         k++;
      end while (!(prev_req && imem_req && !imem_ack && cnt >= 2) && k < 20);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0102;
      bench_discard = 1;
      exp_idx = 32'h40;
      prev_req = 0;
      step();
      redirect_valid = 1'b0;
      chk("redir_valid", 32'(instr_valid), 32'd0);
      chk("redir_addr", 32'(imem_addr), 32'h40);
      run_pops(pops + 1, 20, "redir");
      chk("redir_pc_out", pc_out, 32'h0000_0100);
      chk("redir_discard", 32'(bench_discard), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
